// File: rtl/binary_mul_acc_4_1.sv
// Signed dot-product accumulator placed behind the pipelined 4x4 multiplier.
// A {valid,last} tag rides a delay line matched to the multiplier so each tag meets its product.
module binary_mul_acc_4_1 #(
   parameter int LATENCY = 5,
   parameter int P_W     = 7,
   parameter int ACC_W   = 12,
   parameter int CNT_W   = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic                    in_last,
   input  logic signed [P_W-1:0]   P,
   output logic signed [ACC_W-1:0] sum,
   output logic                    sum_valid,
   output logic [CNT_W-1:0]        n_terms,
   output logic                    ovf,
   output logic                    busy
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACC  = 1'b1;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]        CNT_MAX = '1;

   function automatic logic signed [ACC_W:0] sext_p(input logic signed [P_W-1:0] p);
      return {{(ACC_W+1-P_W){p[P_W-1]}}, p};
   endfunction

   // The two top bits of the widened sum disagree exactly when ACC_W bits cannot hold it.
   function automatic logic is_clamped(input logic signed [ACC_W:0] x);
      return x[ACC_W] != x[ACC_W-1];
   endfunction

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
      logic signed [ACC_W-1:0] r;
      if (is_clamped(x))
         r = x[ACC_W] ? ACC_MIN : ACC_MAX;
      else
         r = x[ACC_W-1:0];
      return r;
   endfunction

   logic [LATENCY-1:0]      tag_vld_p0;
   logic [LATENCY-1:0]      tag_lst_p0;
   logic                    dv;
   logic                    dl;
   logic [0:0]              state_p1;
   logic signed [ACC_W-1:0] acc_p1;
   logic [CNT_W-1:0]        cnt_p1;
   logic                    ovf_i_p1;
   logic signed [ACC_W:0]   p_ext;
   logic signed [ACC_W:0]   acc_ext;
   logic signed [ACC_W:0]   acc_raw;
   logic signed [ACC_W-1:0] acc_sat;
   logic                    clamp;
   logic                    cnt_full;
   logic [CNT_W-1:0]        cnt_inc;
   logic                    step;

   // Stage p0: tag delay line, shifted in lockstep with the multiplier; bit 0 is the entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_p0 <= '0;
         tag_lst_p0 <= '0;
      end else if (en) begin
         tag_vld_p0 <= (tag_vld_p0 << 1) | LATENCY'(in_valid);
         tag_lst_p0 <= (tag_lst_p0 << 1) | LATENCY'(in_valid & in_last);
      end
   end

   assign dv = tag_vld_p0[LATENCY-1];
   assign dl = tag_lst_p0[LATENCY-1];

   assign p_ext    = sext_p(P);
   assign acc_ext  = {acc_p1[ACC_W-1], acc_p1};
   assign acc_raw  = acc_ext + p_ext;
   assign acc_sat  = sat_acc(acc_raw);
   assign clamp    = is_clamped(acc_raw);
   assign cnt_full = (cnt_p1 == CNT_MAX);
   assign cnt_inc  = cnt_full ? CNT_MAX : cnt_p1 + CNT_ONE;
   assign step     = en & dv;

   // Stage p1: accumulate the aligned product and emit on the tagged last term.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p1  <= IDLE;
         acc_p1    <= '0;
         cnt_p1    <= '0;
         ovf_i_p1  <= 1'b0;
         sum       <= '0;
         sum_valid <= 1'b0;
         n_terms   <= '0;
         ovf       <= 1'b0;
      end else begin
         sum_valid <= 1'b0;
         if (step) begin
            case (state_p1)
               IDLE: begin
                  if (dl) begin
                     sum       <= sat_acc(p_ext);
                     n_terms   <= CNT_ONE;
                     ovf       <= 1'b0;
                     sum_valid <= 1'b1;
                  end else begin
                     state_p1 <= ACC;
                     acc_p1   <= p_ext[ACC_W-1:0];
                     cnt_p1   <= CNT_ONE;
                     ovf_i_p1 <= 1'b0;
                  end
               end
               ACC: begin
                  if (dl) begin
                     sum       <= acc_sat;
                     n_terms   <= cnt_inc;
                     ovf       <= ovf_i_p1 | clamp | cnt_full;
                     sum_valid <= 1'b1;
                     state_p1  <= IDLE;
                     acc_p1    <= '0;
                     cnt_p1    <= '0;
                     ovf_i_p1  <= 1'b0;
                  end else begin
                     acc_p1   <= acc_sat;
                     cnt_p1   <= cnt_inc;
                     ovf_i_p1 <= ovf_i_p1 | clamp | cnt_full;
                  end
               end
               default: state_p1 <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state_p1 == ACC) | (|tag_vld_p0);

endmodule
